// File: rtl/usb_rx_deser_pkg.sv
// Shared definitions for the USB receive byte assembler: state encoding,
// SYNC pattern and the shift-register helper.
package usb_rx_deser_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StData = 1'b1
  } rx_state_e;

  // SYNC as it appears after LSB-first assembly (wire order 0000_0001).
  localparam logic [7:0] SyncPattern = 8'h80;
  // Head of a SYNC that lost leading zeros in a repeater: >=5 zeros then the 1.
  localparam logic [5:0] SyncRelaxHead = 6'b100000;
  localparam int unsigned DefByteCntW = 11;

  // Window seen when bit_i is shifted in at the MSB end.
  function automatic logic [7:0] shift_in(input logic bit_i, input logic [7:0] sh);
    return {bit_i, sh[7:1]};
  endfunction

endpackage

// File: rtl/usb_rx_deser_if.sv
// Bus between the bit-unstuff/controller side (master) and the receive
// byte assembler (slave).
interface usb_rx_deser_if #(
  parameter int unsigned ByteCntW = usb_rx_deser_pkg::DefByteCntW
) ();

  logic                RDI;
  logic                RCS;
  logic                halt_rx_shift;
  logic                RX_EOP;
  logic                RX_ACK;
  logic [7:0]          RX_DATA;
  logic                RX_VALID;
  logic                RX_SYNC_DET;
  logic                RX_LAST_BYTE;
  logic                RX_ERR;
  logic                RX_OVERRUN;
  logic [ByteCntW-1:0] RX_BYTE_CNT;
  logic                rx_crc_shift;
  logic                rx_crc_init;

  modport master (
    output RDI, RCS, halt_rx_shift, RX_EOP, RX_ACK,
    input  RX_DATA, RX_VALID, RX_SYNC_DET, RX_LAST_BYTE, RX_ERR, RX_OVERRUN,
    input  RX_BYTE_CNT, rx_crc_shift, rx_crc_init
  );

  modport slave (
    input  RDI, RCS, halt_rx_shift, RX_EOP, RX_ACK,
    output RX_DATA, RX_VALID, RX_SYNC_DET, RX_LAST_BYTE, RX_ERR, RX_OVERRUN,
    output RX_BYTE_CNT, rx_crc_shift, rx_crc_init
  );

endinterface

// File: rtl/usb_rx_deser_sync_det.sv
// Windowed SYNC compare. Optional feature macro: RX_SYNC_RELAX_EN, which also
// accepts a SYNC whose leading zeros were partly dropped upstream.
module usb_rx_deser_sync_det
  import usb_rx_deser_pkg::*;
#(
  parameter logic [7:0] Pattern = SyncPattern
) (
  input  logic       acc_i,
  input  logic [7:0] win_i,
  output logic       hit_o
);

  // Match the window formed by the incoming bit and the shift register.
  always_comb begin
    hit_o = acc_i && (win_i == Pattern);
`ifdef RX_SYNC_RELAX_EN
    if (acc_i && (win_i[7:2] == SyncRelaxHead)) begin
      hit_o = 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/usb_rx_deser.sv
// USB 2.0 receive byte assembler: SYNC hunt, LSB-first byte assembly,
// one-deep holding register with valid/ack, EOP classification.
// Optional feature macro: RX_SYNC_RELAX_EN (see usb_rx_deser_sync_det).
module usb_rx_deser
  import usb_rx_deser_pkg::*;
#(
  parameter int unsigned ByteCntW = DefByteCntW,
  parameter logic [7:0]  SyncPat  = SyncPattern
) (
  input logic           clock,
  input logic           reset,
  usb_rx_deser_if.slave bus
);

  localparam logic [ByteCntW-1:0] CntOne = ByteCntW'(1);

  rx_state_e           state_q;
  logic [7:0]          shreg_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic                sync_det_q;
  logic                crc_init_q;
  logic                last_q;
  logic                err_q;
  logic                overrun_q;
  logic [ByteCntW-1:0] byte_cnt_q;

  logic       acc;
  logic [7:0] win;
  logic       sync_hit;
  logic       byte_done;
  logic [2:0] bit_cnt_nxt;

  assign acc         = bus.RCS & ~bus.halt_rx_shift;
  assign win         = shift_in(bus.RDI, shreg_q);
  assign bit_cnt_nxt = acc ? bit_cnt_q + 3'd1 : bit_cnt_q;
  assign byte_done   = acc && (state_q == StData) && (bit_cnt_q == 3'd7);

  usb_rx_deser_sync_det #(
    .Pattern (SyncPat)
  ) u_sync_det (
    .acc_i (acc),
    .win_i (win),
    .hit_o (sync_hit)
  );

  // Receive FSM, datapath and holding register with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StHunt;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sync_det_q <= 1'b0;
      crc_init_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      sync_det_q <= 1'b0;
      crc_init_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      if (acc) begin
        shreg_q <= win;
      end
      if (valid_q && bus.RX_ACK) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        StHunt: begin
          // EOP is meaningless before a SYNC and is ignored here.
          if (sync_hit) begin
            state_q    <= StData;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
            sync_det_q <= 1'b1;
            crc_init_q <= 1'b1;
          end
        end
        StData: begin
          bit_cnt_q <= bit_cnt_nxt;
          if (byte_done) begin
            if (byte_cnt_q != '1) begin
              byte_cnt_q <= byte_cnt_q + CntOne;
            end
            // An ack in the same cycle frees the holding register for the new byte.
            if (!valid_q || bus.RX_ACK) begin
              data_q  <= win;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          // Classify on the count after this cycle's bit so a completing bit counts.
          if (bus.RX_EOP) begin
            if (bit_cnt_nxt == 3'd0) begin
              last_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q   <= StHunt;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign bus.RX_DATA      = data_q;
  assign bus.RX_VALID     = valid_q;
  assign bus.RX_SYNC_DET  = sync_det_q;
  assign bus.RX_LAST_BYTE = last_q;
  assign bus.RX_ERR       = err_q;
  assign bus.RX_OVERRUN   = overrun_q;
  assign bus.RX_BYTE_CNT  = byte_cnt_q;
  assign bus.rx_crc_init  = crc_init_q;
  // Bits after the PID byte feed the CRC checker in the cycle they arrive.
  assign bus.rx_crc_shift = acc && (state_q == StData) && (byte_cnt_q != '0);

endmodule
